// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 word multiplexer built as a radix-4 tree with a register stage per level.
// Optional out-of-range select detection is enabled by defining MUX_TREE_PIPE_SEL_CHECK_EN.
module mux_tree_pipe #(
    parameter int unsigned M = 8,
    parameter int unsigned N = 16,
    localparam int unsigned SW = $clog2(N),
    localparam int unsigned LEVELS = (SW + 1) / 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [N*M-1:0]    in_data_i,
    input  logic [SW-1:0]     sel_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [M-1:0]      out_data_o,
    output logic              err_o
);

    // Input vector padded to a power of two; missing words read as zero.
    localparam int unsigned NP = 1 << SW;

    logic [LEVELS-1:0] valid_v;
    logic [LEVELS:0]   ready_v;
    logic [NP*M-1:0]   in_pad;

    assign ready_v[LEVELS] = out_ready_i;
    assign in_ready_o      = ready_v[0];
    assign out_valid_o     = valid_v[LEVELS-1];

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    logic sel_bad_c;
    logic err_q;

    assign sel_bad_c = 32'(sel_i) >= N;

    // Sticky flag: only reset clears it, flush leaves it alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (ready_v[0] && in_valid_i && !flush_i && sel_bad_c) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    always_comb begin
        in_pad = '0;
        if (!sel_bad_c) begin
            in_pad[N*M-1:0] = in_data_i;
        end
    end
`else
    assign err_o = 1'b0;

    always_comb begin
        in_pad = '0;
        in_pad[N*M-1:0] = in_data_i;
    end
`endif

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned SIN  = SW - 2 * l;
        localparam int unsigned SB   = (SIN >= 2) ? 2 : 1;
        localparam int unsigned RED  = 1 << SB;
        localparam int unsigned WIN  = 1 << SIN;
        localparam int unsigned WOUT = WIN / RED;

        logic [WIN*M-1:0]  vec_in;
        logic [SIN-1:0]    sel_in;
        logic              valid_in;
        logic [WOUT*M-1:0] red_c;
        logic [WOUT*M-1:0] data_q;
        logic              valid_q;

        if (l == 0) begin : g_src
            assign vec_in   = in_pad;
            assign sel_in   = sel_i;
            assign valid_in = in_valid_i;
        end else begin : g_src
            assign vec_in   = g_lvl[l-1].data_q;
            assign sel_in   = g_lvl[l-1].g_sel.sel_q;
            assign valid_in = g_lvl[l-1].valid_q;
        end

        // One reducer per group; the final stage is 2:1 when the select width is odd.
        for (genvar g = 0; g < WOUT; g++) begin : g_grp
            if (RED == 4) begin : g_r4
                assign red_c[g*M +: M] = sel_in[1]
                    ? (sel_in[0] ? vec_in[(4*g+3)*M +: M] : vec_in[(4*g+2)*M +: M])
                    : (sel_in[0] ? vec_in[(4*g+1)*M +: M] : vec_in[(4*g)*M +: M]);
            end else begin : g_r2
                assign red_c[g*M +: M] = sel_in[0] ? vec_in[(2*g+1)*M +: M]
                                                   : vec_in[(2*g)*M +: M];
            end
        end

        assign valid_v[l] = valid_q;
        assign ready_v[l] = !valid_q || ready_v[l+1];

        // Stage register; bubbles advance the valid bit without touching data.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end else if (ready_v[l]) begin
                valid_q <= valid_in;
                if (valid_in) begin
                    data_q <= red_c;
                end
            end
        end

        if (l < LEVELS - 1) begin : g_sel
            logic [SIN-SB-1:0] sel_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sel_q <= '0;
                end else if (!flush_i && ready_v[l] && valid_in) begin
                    sel_q <= sel_in[SIN-1:SB];
                end
            end
        end else begin : g_last
            assign out_data_o = data_q;
        end
    end

endmodule
